// File: rtl/ps2_packet_tx.sv
// ps2_packet_tx: turns 24-bit PS/2 mouse packets into a byte stream.
// Each packet goes out as byte1 = [23:16], byte2 = [15:8], byte3 = [7:0],
// then IDLE_GAP filler bytes with bit3 cleared. A downstream framer that
// locks on bit3 of byte1 can therefore always find the packet boundary.
// Byte1 bit3 (packet bit19) is always forced to 1.
// Optional build macro PS2TX_SKID_EN adds a one-entry input skid buffer.
// With that buffer, packets can be accepted while a transfer is in flight
// and can be sent back-to-back.
//
//  state | meaning
//  IDLE  | nothing to send; accepting a packet
//  B1    | presenting byte1 (packet[23:16], bit3 forced high)
//  B2    | presenting byte2 (packet[15:8])
//  B3    | presenting byte3 (packet[7:0])
//  GAP   | presenting filler bytes; gap_cnt counts accepted fillers
module ps2_packet_tx #(
    parameter int          IDLE_GAP  = 1,
    parameter logic [7:0]  FILL_BYTE = 8'h00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [23:0] in_bytes,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [7:0]  out_byte,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        pkt_done,
    output logic        sync_fix
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_B1   = 3'd1,
        S_B2   = 3'd2,
        S_B3   = 3'd3,
        S_GAP  = 3'd4
    } state_t;

    localparam logic [23:0] SYNC_BIT  = 24'h08_0000;
    localparam logic [7:0]  FILL_OUT  = FILL_BYTE & 8'hF7;
    localparam logic [3:0]  GAP_LAST  = (IDLE_GAP > 0) ? 4'(IDLE_GAP - 1) : 4'd0;

    state_t      state;
    state_t      state_nxt;
    logic [23:0] pkt;
    logic [23:0] pkt_nxt;
    logic [3:0]  gap_cnt;
    logic [3:0]  gap_cnt_nxt;
    logic        fire;
    logic        accept;
    logic        eop;

`ifdef PS2TX_SKID_EN
    logic [23:0] skid;
    logic [23:0] skid_nxt;
    logic        skid_full;
    logic        skid_full_nxt;

    assign in_ready = !skid_full;
`else
    assign in_ready = (state == S_IDLE);
`endif

    assign fire   = out_valid && out_ready;
    assign accept = in_valid && in_ready;

    // Output byte and valid follow directly from the current state.
    always_comb begin
        out_valid = 1'b0;
        out_byte  = 8'h00;
        case (state)
            S_B1: begin
                out_valid = 1'b1;
                out_byte  = pkt[23:16];
            end
            S_B2: begin
                out_valid = 1'b1;
                out_byte  = pkt[15:8];
            end
            S_B3: begin
                out_valid = 1'b1;
                out_byte  = pkt[7:0];
            end
            S_GAP: begin
                out_valid = 1'b1;
                out_byte  = FILL_OUT;
            end
            default: begin
                out_valid = 1'b0;
                out_byte  = 8'h00;
            end
        endcase
    end

    // Next-state, packet register, gap counter and skid buffer updates.
    always_comb begin
        state_nxt   = state;
        pkt_nxt     = pkt;
        gap_cnt_nxt = gap_cnt;
        eop         = 1'b0;
`ifdef PS2TX_SKID_EN
        skid_nxt      = skid;
        skid_full_nxt = skid_full;
`endif
        case (state)
            S_IDLE: begin
                if (accept) begin
                    pkt_nxt   = in_bytes | SYNC_BIT;
                    state_nxt = S_B1;
                end
            end
            S_B1: begin
                if (fire) state_nxt = S_B2;
            end
            S_B2: begin
                if (fire) state_nxt = S_B3;
            end
            S_B3: begin
                if (fire) begin
                    if (IDLE_GAP > 0) begin
                        state_nxt   = S_GAP;
                        gap_cnt_nxt = 4'd0;
                    end else begin
                        eop = 1'b1;
                    end
                end
            end
            S_GAP: begin
                if (fire) begin
                    gap_cnt_nxt = gap_cnt + 4'd1;
                    if (gap_cnt == GAP_LAST) eop = 1'b1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase

        if (eop) begin
            state_nxt   = S_IDLE;
            gap_cnt_nxt = 4'd0;
`ifdef PS2TX_SKID_EN
            // Drain a buffered packet, or pass a packet arriving right now
            // straight through, so consecutive packets have no idle bubble.
            if (skid_full) begin
                pkt_nxt       = skid;
                skid_full_nxt = 1'b0;
                state_nxt     = S_B1;
            end else if (accept) begin
                pkt_nxt   = in_bytes | SYNC_BIT;
                state_nxt = S_B1;
            end
`endif
        end

`ifdef PS2TX_SKID_EN
        // Anything accepted mid-transfer that was not passed through lands in the buffer.
        if (accept && (state != S_IDLE) && !(eop && !skid_full)) begin
            skid_nxt      = in_bytes | SYNC_BIT;
            skid_full_nxt = 1'b1;
        end
`endif
    end

    // State register plus the registered pkt_done / sync_fix pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            pkt      <= 24'h0;
            gap_cnt  <= 4'd0;
            pkt_done <= 1'b0;
            sync_fix <= 1'b0;
`ifdef PS2TX_SKID_EN
            skid      <= 24'h0;
            skid_full <= 1'b0;
`endif
        end else begin
            state    <= state_nxt;
            pkt      <= pkt_nxt;
            gap_cnt  <= gap_cnt_nxt;
            pkt_done <= (state == S_B3) && fire;
            sync_fix <= accept && !in_bytes[19];
`ifdef PS2TX_SKID_EN
            skid      <= skid_nxt;
            skid_full <= skid_full_nxt;
`endif
        end
    end

endmodule
